armleo_axi_bram: RTL and testbench
==================================

ARMLEO_AXI_BRAM -- requirements
Module: armleo_axi_bram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data bus width (32 or 64).
REQ-003 SHALL have parameter ID_WIDTH, default 4, transaction ID width.
REQ-004 SHALL have parameter DEPTH, default 1024, memory size in DATA_WIDTH words.
REQ-005 SHALL have parameter BASE_ADDR, default 0, byte address of word 0.
REQ-006 SHALL have port clk, input, 1, single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have AW bundle axi_aw*, input except awready, as follows: valid/ready 1, addr ADDR_WIDTH, len 8, size 3, burst 2, lock 1, id ID_WIDTH, prot 3.
REQ-009 SHALL have W bundle axi_w*, input except wready, as follows: valid/ready 1, data DATA_WIDTH, strb DATA_WIDTH/8, last 1.
REQ-010 SHALL have B bundle axi_b*, output except bready, as follows: valid/ready 1, id ID_WIDTH, resp 2.
REQ-011 SHALL have AR bundle axi_ar*, same fields as AW, input except arready.
REQ-012 SHALL have R bundle axi_r*, output except rready, as follows: valid/ready 1, data DATA_WIDTH, id ID_WIDTH, resp 2, last 1.

Function
REQ-013 SHALL act as AXI4 responder, one transaction at a time; FSM states IDLE, WRITE, WRITE_RESP, READ_FETCH, READ_DATA.
REQ-014 IDLE: SHALL raise awready or arready (never both) combinationally from valid; handshake latches id/addr/len/size/burst and moves to WRITE or READ_FETCH.
REQ-015 AW and AR both valid in IDLE: SHALL grant the channel not granted last; after reset, write wins first.
REQ-016 WRITE: wready=1; each wvalid beat SHALL write only bytes with strb=1, then advance the address.
REQ-017 On accepted wlast, or after len+1 beats, SHALL go to WRITE_RESP; a wlast mismatch with len SHALL force SLVERR.
REQ-018 WRITE_RESP: bvalid=1 holding bid/bresp stable until bready, then IDLE.
REQ-019 READ_FETCH: SHALL issue the synchronous memory read, one cycle; READ_DATA: rvalid=1, data/id/resp/last stable until rready.
REQ-020 On rready in READ_DATA, SHALL go to READ_FETCH for the next beat, or to IDLE after the last beat; peak read rate one beat per 2 cycles.
REQ-021 Address update rules: FIXED unchanged; INCR adds 2^size; WRAP adds 2^size within an aligned window of (len+1)*2^size bytes.
REQ-022 Any of the following SHALL make the whole burst SLVERR with no memory write and rdata=0: size > log2(DATA_WIDTH/8), burst=2'b11, WRAP with len not in {1,3,7,15}, or WRAP with unaligned address.
REQ-023 Beat address outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_WIDTH/8): SHALL give DECERR, suppress the write, and return rdata=0; bresp SHALL report the worst beat (SLVERR > DECERR > OKAY).
REQ-024 rresp SHALL be per beat; rlast=1 only on beat len.
REQ-025 Narrow transfers SHALL use byte lanes selected by address; bytes written via strobe only.
REQ-026 lock and prot SHALL be ignored; exclusive access is never reported (no EXOKAY).

Reset
REQ-027 While rst_n=0: state=IDLE; awready, wready, arready, bvalid, rvalid = 0; bid, bresp, rid, rresp, rdata, rlast = 0; arbitration pointer selects write.
REQ-028 Reset asserted mid-burst SHALL abort the burst immediately; writes already committed SHALL stay in memory; memory contents SHALL NOT be reset.

Structure
REQ-029 Burst encodings (FIXED/INCR/WRAP) and resp encodings (OKAY/EXOKAY/SLVERR/DECERR) SHALL live in shared package armleo_axi_pkg.
REQ-030 Next-address and wrap-boundary calculation SHALL be sub-module armleo_axi_burst_addr_gen (addr, len, size, burst in; next_addr, error out), reused by AW and AR paths.

Verification
REQ-031 Write INCR at 0x10, len=3, size=2, strb=0xF, data 1..4 -> bresp OKAY; then AR INCR at 0x10, len=3 -> rdata 1,2,3,4, rlast only on 4th beat.
REQ-032 WRAP at 0x18, len=3, size=2 -> beat addresses 0x18, 0x1C, 0x10, 0x14.
REQ-033 AW and AR valid in the same cycle after reset -> write granted first, read next; second simultaneous pair -> read granted first.
REQ-034 AR at BASE_ADDR+DEPTH*4, len=1 -> two beats, rresp DECERR, rdata 0; write to the same address -> bresp DECERR, memory unchanged.
REQ-035 strb=0x5 over 0xFFFFFFFF with data 0x11223344 -> readback 0xFF22FF44; burst=2'b11 -> SLVERR and no write.
REQ-036 rst_n pulsed low during beat 2 of len=7 read -> rvalid=0 that cycle, FSM in IDLE, next AR served normally.

Source files
------------

// File: rtl/armleo_axi_pkg.sv
// ---------------------------------------------------------------------------
// armleo_axi_pkg
// Shared AXI4 encodings used by the BRAM responder and its address helper:
//   axiBurst_t  - AxBURST field (FIXED / INCR / WRAP / reserved)
//   axiResp_t   - xRESP field (OKAY / EXOKAY / SLVERR / DECERR)
//   bramState_t - transaction FSM states of the BRAM responder
//   worseResp() - merges two responses, keeping the most severe one
// ---------------------------------------------------------------------------
package armleo_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED    = 2'b00,
        BURST_INCR     = 2'b01,
        BURST_WRAP     = 2'b10,
        BURST_RESERVED = 2'b11
    } axiBurst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axiResp_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRITE_RESP,
        READ_FETCH,
        READ_DATA
    } bramState_t;

    // Severity order for the final write response: SLVERR beats DECERR beats OKAY.
    // EXOKAY never appears here because exclusive access is not supported.
    function automatic axiResp_t worseResp(input axiResp_t a, input axiResp_t b);
        if (a == RESP_SLVERR || b == RESP_SLVERR) begin
            return RESP_SLVERR;
        end
        if (a == RESP_DECERR || b == RESP_DECERR) begin
            return RESP_DECERR;
        end
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/armleo_axi_bram_if.sv
// ---------------------------------------------------------------------------
// armleo_axi_bram_if
// AXI4 bus bundle between a master and the BRAM responder.
//   AW: axi_awvalid/awready, awaddr, awlen, awsize, awburst, awlock, awid, awprot
//   W : axi_wvalid/wready, wdata, wstrb, wlast
//   B : axi_bvalid/bready, bid, bresp
//   AR: axi_arvalid/arready, araddr, arlen, arsize, arburst, arlock, arid, arprot
//   R : axi_rvalid/rready, rdata, rid, rresp, rlast
// Modports: master (drives requests) and slave (responds).
// ---------------------------------------------------------------------------
interface armleo_axi_bram_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);

    logic                    axi_awvalid;
    logic                    axi_awready;
    logic [ADDR_WIDTH-1:0]   axi_awaddr;
    logic [7:0]              axi_awlen;
    logic [2:0]              axi_awsize;
    logic [1:0]              axi_awburst;
    logic                    axi_awlock;
    logic [ID_WIDTH-1:0]     axi_awid;
    logic [2:0]              axi_awprot;

    logic                    axi_wvalid;
    logic                    axi_wready;
    logic [DATA_WIDTH-1:0]   axi_wdata;
    logic [DATA_WIDTH/8-1:0] axi_wstrb;
    logic                    axi_wlast;

    logic                    axi_bvalid;
    logic                    axi_bready;
    logic [ID_WIDTH-1:0]     axi_bid;
    logic [1:0]              axi_bresp;

    logic                    axi_arvalid;
    logic                    axi_arready;
    logic [ADDR_WIDTH-1:0]   axi_araddr;
    logic [7:0]              axi_arlen;
    logic [2:0]              axi_arsize;
    logic [1:0]              axi_arburst;
    logic                    axi_arlock;
    logic [ID_WIDTH-1:0]     axi_arid;
    logic [2:0]              axi_arprot;

    logic                    axi_rvalid;
    logic                    axi_rready;
    logic [DATA_WIDTH-1:0]   axi_rdata;
    logic [ID_WIDTH-1:0]     axi_rid;
    logic [1:0]              axi_rresp;
    logic                    axi_rlast;

    modport master (
        output axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
               axi_awlock, axi_awid, axi_awprot,
        input  axi_awready,
        output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
        input  axi_wready,
        input  axi_bvalid, axi_bid, axi_bresp,
        output axi_bready,
        output axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
               axi_arlock, axi_arid, axi_arprot,
        input  axi_arready,
        input  axi_rvalid, axi_rdata, axi_rid, axi_rresp, axi_rlast,
        output axi_rready
    );

    modport slave (
        input  axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
               axi_awlock, axi_awid, axi_awprot,
        output axi_awready,
        input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
        output axi_wready,
        output axi_bvalid, axi_bid, axi_bresp,
        input  axi_bready,
        input  axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
               axi_arlock, axi_arid, axi_arprot,
        output axi_arready,
        output axi_rvalid, axi_rdata, axi_rid, axi_rresp, axi_rlast,
        input  axi_rready
    );

endinterface

// File: rtl/armleo_axi_burst_addr_gen.sv
// ---------------------------------------------------------------------------
// armleo_axi_burst_addr_gen
// Combinational AXI4 burst address stepper, shared by the write and read paths.
//   i_addr      - current beat byte address
//   i_len       - AxLEN (beats - 1)
//   i_size      - AxSIZE (log2 bytes per beat)
//   i_burst     - AxBURST
//   o_next_addr - byte address of the following beat
//   o_error     - burst parameters the responder cannot honour (SLVERR)
// ---------------------------------------------------------------------------
module armleo_axi_burst_addr_gen
    import armleo_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_SIZE   = 2
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_len,
    input  logic [2:0]            i_size,
    input  logic [1:0]            i_burst,
    output logic [ADDR_WIDTH-1:0] o_next_addr,
    output logic                  o_error
);

    logic [ADDR_WIDTH-1:0] w_beatBytes;
    logic [ADDR_WIDTH-1:0] w_sizeMask;
    logic [ADDR_WIDTH-1:0] w_incrAddr;
    logic [ADDR_WIDTH-1:0] w_wrapMask;

    // INCR steps from the size-aligned address so an unaligned first beat
    // lands on the natural beat grid afterwards; aligned starts are unaffected.
    assign w_beatBytes = ADDR_WIDTH'(1) << i_size;
    assign w_sizeMask  = w_beatBytes - ADDR_WIDTH'(1);
    assign w_incrAddr  = (i_addr & ~w_sizeMask) + w_beatBytes;

    // The wrap window spans (len+1) beats and is aligned to its own size.
    assign w_wrapMask  = ((ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size) - ADDR_WIDTH'(1);

    // Next-address selection plus legality checks of the burst descriptor.
    always_comb begin
        o_next_addr = i_addr;
        o_error     = 1'b0;
        case (i_burst)
            BURST_FIXED: o_next_addr = i_addr;
            BURST_INCR:  o_next_addr = w_incrAddr;
            BURST_WRAP:  o_next_addr = (i_addr & ~w_wrapMask) | (w_incrAddr & w_wrapMask);
            default:     o_error     = 1'b1;
        endcase
        if (i_size > 3'(MAX_SIZE)) begin
            o_error = 1'b1;
        end
        if (i_burst == BURST_WRAP) begin
            if (!(i_len inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
                o_error = 1'b1;
            end
            if ((i_addr & w_sizeMask) != '0) begin
                o_error = 1'b1;
            end
        end
    end

endmodule

// File: rtl/armleo_axi_bram.sv
// ---------------------------------------------------------------------------
// armleo_axi_bram
// AXI4 responder in front of a single-port synchronous block RAM, serving one
// transaction at a time.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (memory contents are kept)
//   axi   - armleo_axi_bram_if.slave: AW, W, B, AR and R channels
// Parameters: ADDR_WIDTH, DATA_WIDTH (32/64), ID_WIDTH, DEPTH (words),
// BASE_ADDR (byte address of word 0).
// ---------------------------------------------------------------------------
module armleo_axi_bram
    import armleo_axi_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input logic              clk,
    input logic              rst_n,
    armleo_axi_bram_if.slave axi
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BYTE_OFFS  = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_END =
        {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(DEPTH * STRB_WIDTH);

    bramState_t            r_state;
    logic                  r_prioWrite;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [7:0]            r_beatCnt;
    logic                  r_burstErr;
    axiResp_t              r_worstResp;
    logic [ID_WIDTH-1:0]   r_bid;
    axiResp_t              r_bresp;
    logic [ID_WIDTH-1:0]   r_rid;
    axiResp_t              r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rlast;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_pickWrite;
    logic                  w_awGrant;
    logic                  w_arGrant;
    logic                  w_bothValid;
    logic [ADDR_WIDTH-1:0] w_agAddr;
    logic [7:0]            w_agLen;
    logic [2:0]            w_agSize;
    logic [1:0]            w_agBurst;
    logic [ADDR_WIDTH-1:0] w_nextAddr;
    logic                  w_agError;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic [IDX_WIDTH-1:0]  w_wordIdx;
    logic                  w_inRange;
    logic                  w_lastBeat;
    logic                  w_memWe;
    axiResp_t              w_beatResp;
    axiResp_t              w_accResp;
    axiResp_t              w_lastResp;
    axiResp_t              w_finalResp;
    logic                  w_unused;

    // Arbitration: the pointer only moves when both requests compete, so a
    // lone request never steals the next contested slot from the other side.
    // Reset is folded into the ready terms so nothing handshakes during reset.
    assign w_bothValid = axi.axi_awvalid && axi.axi_arvalid;
    assign w_pickWrite = axi.axi_awvalid && (!axi.axi_arvalid || r_prioWrite);
    assign w_awGrant   = rst_n && (r_state == IDLE) && w_pickWrite;
    assign w_arGrant   = rst_n && (r_state == IDLE) && axi.axi_arvalid && !w_pickWrite;

    assign axi.axi_awready = w_awGrant;
    assign axi.axi_arready = w_arGrant;
    assign axi.axi_wready  = (r_state == WRITE);
    assign axi.axi_bvalid  = (r_state == WRITE_RESP);
    assign axi.axi_rvalid  = (r_state == READ_DATA);
    assign axi.axi_bid     = r_bid;
    assign axi.axi_bresp   = r_bresp;
    assign axi.axi_rid     = r_rid;
    assign axi.axi_rresp   = r_rresp;
    assign axi.axi_rdata   = r_rdata;
    assign axi.axi_rlast   = r_rlast;

    // In IDLE the address generator checks the request about to be accepted;
    // during a burst it steps the latched beat address.
    assign w_agAddr  = (r_state != IDLE) ? r_addr  : (w_pickWrite ? axi.axi_awaddr  : axi.axi_araddr);
    assign w_agLen   = (r_state != IDLE) ? r_len   : (w_pickWrite ? axi.axi_awlen   : axi.axi_arlen);
    assign w_agSize  = (r_state != IDLE) ? r_size  : (w_pickWrite ? axi.axi_awsize  : axi.axi_arsize);
    assign w_agBurst = (r_state != IDLE) ? r_burst : (w_pickWrite ? axi.axi_awburst : axi.axi_arburst);

    armleo_axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_SIZE   (BYTE_OFFS)
    ) u_addrGen (
        .i_addr      (w_agAddr),
        .i_len       (w_agLen),
        .i_size      (w_agSize),
        .i_burst     (w_agBurst),
        .o_next_addr (w_nextAddr),
        .o_error     (w_agError)
    );

    // Per-beat decode: address window check, word index and beat response.
    assign w_offset    = r_addr - BASE_ADDR;
    assign w_wordIdx   = w_offset[BYTE_OFFS +: IDX_WIDTH];
    assign w_inRange   = ({1'b0, r_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, r_addr} < MEM_END);
    assign w_beatResp  = r_burstErr ? RESP_SLVERR : (w_inRange ? RESP_OKAY : RESP_DECERR);
    assign w_lastBeat  = (r_beatCnt == r_len);
    assign w_accResp   = worseResp(r_worstResp, w_beatResp);
    assign w_lastResp  = (axi.axi_wlast != w_lastBeat) ? RESP_SLVERR : RESP_OKAY;
    assign w_finalResp = worseResp(w_accResp, w_lastResp);
    assign w_memWe     = (r_state == WRITE) && axi.axi_wvalid && !r_burstErr && w_inRange;

    assign w_unused = ^{axi.axi_awlock, axi.axi_awprot, axi.axi_arlock, axi.axi_arprot, w_offset};

    // Memory array: byte-granular writes gated by strobe, never reset so that
    // data committed before a reset survives it.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (axi.axi_wstrb[b]) begin
                    r_mem[w_wordIdx][b*8 +: 8] <= axi.axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Transaction FSM with all channel response fields registered. A reset
    // drops any burst in flight straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_prioWrite <= 1'b1;
            r_id        <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_beatCnt   <= '0;
            r_burstErr  <= 1'b0;
            r_worstResp <= RESP_OKAY;
            r_bid       <= '0;
            r_bresp     <= RESP_OKAY;
            r_rid       <= '0;
            r_rresp     <= RESP_OKAY;
            r_rdata     <= '0;
            r_rlast     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_awGrant) begin
                        r_id        <= axi.axi_awid;
                        r_addr      <= axi.axi_awaddr;
                        r_len       <= axi.axi_awlen;
                        r_size      <= axi.axi_awsize;
                        r_burst     <= axi.axi_awburst;
                        r_beatCnt   <= '0;
                        r_burstErr  <= w_agError;
                        r_worstResp <= RESP_OKAY;
                        r_state     <= WRITE;
                        if (w_bothValid) begin
                            r_prioWrite <= 1'b0;
                        end
                    end else if (w_arGrant) begin
                        r_id        <= axi.axi_arid;
                        r_addr      <= axi.axi_araddr;
                        r_len       <= axi.axi_arlen;
                        r_size      <= axi.axi_arsize;
                        r_burst     <= axi.axi_arburst;
                        r_beatCnt   <= '0;
                        r_burstErr  <= w_agError;
                        r_state     <= READ_FETCH;
                        if (w_bothValid) begin
                            r_prioWrite <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (axi.axi_wvalid) begin
                        r_addr      <= w_nextAddr;
                        r_beatCnt   <= r_beatCnt + 8'd1;
                        r_worstResp <= w_accResp;
                        if (axi.axi_wlast || w_lastBeat) begin
                            r_bid   <= r_id;
                            r_bresp <= w_finalResp;
                            r_state <= WRITE_RESP;
                        end
                    end
                end
                WRITE_RESP: begin
                    if (axi.axi_bready) begin
                        r_state <= IDLE;
                    end
                end
                READ_FETCH: begin
                    r_rdata <= (w_beatResp == RESP_OKAY) ? r_mem[w_wordIdx] : '0;
                    r_rresp <= w_beatResp;
                    r_rid   <= r_id;
                    r_rlast <= w_lastBeat;
                    r_state <= READ_DATA;
                end
                READ_DATA: begin
                    if (axi.axi_rready) begin
                        if (r_rlast) begin
                            r_state <= IDLE;
                        end else begin
                            r_addr    <= w_nextAddr;
                            r_beatCnt <= r_beatCnt + 8'd1;
                            r_state   <= READ_FETCH;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_armleo_axi_bram.sv
// ---------------------------------------------------------------------------
// tb_armleo_axi_bram
// Directed bench for armleo_axi_bram: drives the AXI master side of the bus
// interface through small tasks and compares every response against values
// worked out by hand for each vector.
// ---------------------------------------------------------------------------
module tb_armleo_axi_bram;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int IW    = 4;
    localparam int DEPTH = 1024;

    localparam logic [1:0] B_FIXED = 2'd0;
    localparam logic [1:0] B_INCR  = 2'd1;
    localparam logic [1:0] B_WRAP  = 2'd2;
    localparam logic [1:0] B_RSVD  = 2'd3;
    localparam logic [1:0] OKAY    = 2'd0;
    localparam logic [1:0] SLVERR  = 2'd2;
    localparam logic [1:0] DECERR  = 2'd3;
    localparam int         LIMIT   = 100;

    logic clk = 1'b0;
    logic rst_n;
    int   checkCount = 0;
    int   passCount  = 0;

    logic [31:0] rdData [16];
    logic [1:0]  rdResp [16];
    logic        rdLast [16];
    logic [3:0]  rdId   [16];
    logic [1:0]  bRespSeen;
    logic [3:0]  bIdSeen;

    armleo_axi_bram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axiBus ();

    armleo_axi_bram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (32'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .axi   (axiBus)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Safety net in case a handshake loop is broken beyond its own bounds.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time exhausted");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Park every master-driven signal at an idle value.
    task automatic idleInputs();
        axiBus.axi_awvalid = 1'b0; axiBus.axi_awaddr = '0; axiBus.axi_awlen = '0;
        axiBus.axi_awsize  = '0;   axiBus.axi_awburst = '0; axiBus.axi_awlock = 1'b0;
        axiBus.axi_awid    = '0;   axiBus.axi_awprot = '0;
        axiBus.axi_wvalid  = 1'b0; axiBus.axi_wdata = '0; axiBus.axi_wstrb = '0;
        axiBus.axi_wlast   = 1'b0; axiBus.axi_bready = 1'b0;
        axiBus.axi_arvalid = 1'b0; axiBus.axi_araddr = '0; axiBus.axi_arlen = '0;
        axiBus.axi_arsize  = '0;   axiBus.axi_arburst = '0; axiBus.axi_arlock = 1'b0;
        axiBus.axi_arid    = '0;   axiBus.axi_arprot = '0;
        axiBus.axi_rready  = 1'b0;
    endtask

    task automatic setAw(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
        axiBus.axi_awaddr = addr; axiBus.axi_awlen = len; axiBus.axi_awsize = size;
        axiBus.axi_awburst = burst; axiBus.axi_awid = id;
        axiBus.axi_awlock = 1'b1; axiBus.axi_awprot = 3'b101;
    endtask

    task automatic setAr(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
        axiBus.axi_araddr = addr; axiBus.axi_arlen = len; axiBus.axi_arsize = size;
        axiBus.axi_arburst = burst; axiBus.axi_arid = id;
        axiBus.axi_arlock = 1'b1; axiBus.axi_arprot = 3'b011;
    endtask

    task automatic awHandshake();
        int t;
        t = 0;
        axiBus.axi_awvalid = 1'b1;
        #1;
        while (axiBus.axi_awready !== 1'b1 && t < LIMIT) begin
            @(posedge clk); #1; t++;
        end
        if (t >= LIMIT) checkOutput("aw_timeout", axiBus.axi_awready, 1);
        @(posedge clk); #1;
        axiBus.axi_awvalid = 1'b0;
    endtask

    task automatic arHandshake();
        int t;
        t = 0;
        axiBus.axi_arvalid = 1'b1;
        #1;
        while (axiBus.axi_arready !== 1'b1 && t < LIMIT) begin
            @(posedge clk); #1; t++;
        end
        if (t >= LIMIT) checkOutput("ar_timeout", axiBus.axi_arready, 1);
        @(posedge clk); #1;
        axiBus.axi_arvalid = 1'b0;
    endtask

    // Drive nBeats W beats with incrementing data; wlast marks beat lastIdx.
    task automatic writeData(input int nBeats, input int lastIdx, input logic [3:0] strb,
                             input logic [31:0] firstData);
        int t;
        for (int i = 0; i < nBeats; i++) begin
            axiBus.axi_wvalid = 1'b1;
            axiBus.axi_wdata  = firstData + 32'(i);
            axiBus.axi_wstrb  = strb;
            axiBus.axi_wlast  = (i == lastIdx);
            t = 0;
            while (axiBus.axi_wready !== 1'b1 && t < LIMIT) begin
                @(posedge clk); #1; t++;
            end
            if (t >= LIMIT) checkOutput("w_timeout", axiBus.axi_wready, 1);
            @(posedge clk); #1;
        end
        axiBus.axi_wvalid = 1'b0;
        axiBus.axi_wlast  = 1'b0;
    endtask

    task automatic getB();
        int t;
        t = 0;
        axiBus.axi_bready = 1'b1;
        while (axiBus.axi_bvalid !== 1'b1 && t < LIMIT) begin
            @(posedge clk); #1; t++;
        end
        if (t >= LIMIT) checkOutput("b_timeout", axiBus.axi_bvalid, 1);
        bRespSeen = axiBus.axi_bresp;
        bIdSeen   = axiBus.axi_bid;
        @(posedge clk); #1;
        axiBus.axi_bready = 1'b0;
    endtask

    // Collect nBeats R beats into the rd* arrays.
    task automatic readBeats(input int nBeats);
        int t;
        axiBus.axi_rready = 1'b1;
        for (int i = 0; i < nBeats; i++) begin
            t = 0;
            while (axiBus.axi_rvalid !== 1'b1 && t < LIMIT) begin
                @(posedge clk); #1; t++;
            end
            if (t >= LIMIT) checkOutput("r_timeout", axiBus.axi_rvalid, 1);
            rdData[i] = axiBus.axi_rdata;
            rdResp[i] = axiBus.axi_rresp;
            rdLast[i] = axiBus.axi_rlast;
            rdId[i]   = axiBus.axi_rid;
            @(posedge clk); #1;
        end
        axiBus.axi_rready = 1'b0;
    endtask

    task automatic applyWrite(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [3:0] strb, input logic [31:0] firstData);
        setAw(addr, len, size, burst, 4'h1);
        awHandshake();
        writeData(int'(len) + 1, int'(len), strb, firstData);
        getB();
    endtask

    task automatic applyRead(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst);
        setAr(addr, len, size, burst, 4'h2);
        arHandshake();
        readBeats(int'(len) + 1);
    endtask

    initial begin
        idleInputs();
        rst_n = 1'b0;
        // Valid requests during reset must not be accepted.
        axiBus.axi_awvalid = 1'b1;
        axiBus.axi_arvalid = 1'b1;
        #12;
        checkOutput("rst_awready", axiBus.axi_awready, 0);
        checkOutput("rst_arready", axiBus.axi_arready, 0);
        checkOutput("rst_wready",  axiBus.axi_wready,  0);
        checkOutput("rst_bvalid",  axiBus.axi_bvalid,  0);
        checkOutput("rst_rvalid",  axiBus.axi_rvalid,  0);
        checkOutput("rst_rdata",   axiBus.axi_rdata,   0);
        checkOutput("rst_rlast",   axiBus.axi_rlast,   0);
        checkOutput("rst_bresp",   axiBus.axi_bresp,   0);
        axiBus.axi_awvalid = 1'b0;
        axiBus.axi_arvalid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // First contested pair after reset: write wins, read follows.
        setAw(32'h10, 8'd3, 3'd2, B_INCR, 4'h3);
        setAr(32'h10, 8'd3, 3'd2, B_INCR, 4'h5);
        axiBus.axi_awvalid = 1'b1;
        axiBus.axi_arvalid = 1'b1;
        #1;
        checkOutput("arb1_awready", axiBus.axi_awready, 1);
        checkOutput("arb1_arready", axiBus.axi_arready, 0);
        @(posedge clk); #1;
        axiBus.axi_awvalid = 1'b0;
        checkOutput("arb1_ar_held", axiBus.axi_arready, 0);
        writeData(4, 3, 4'hF, 32'd1);
        getB();
        checkOutput("incr_bresp", bRespSeen, OKAY);
        checkOutput("incr_bid",   bIdSeen,   4'h3);
        checkOutput("arb1_ar_next", axiBus.axi_arready, 1);
        @(posedge clk); #1;
        axiBus.axi_arvalid = 1'b0;
        readBeats(4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("incr_rdata%0d", i), rdData[i], 32'(i + 1));
            checkOutput($sformatf("incr_rlast%0d", i), rdLast[i], (i == 3) ? 1 : 0);
            checkOutput($sformatf("incr_rresp%0d", i), rdResp[i], OKAY);
        end
        checkOutput("incr_rid", rdId[0], 4'h5);

        // Second contested pair: read wins this time.
        setAw(32'h40, 8'd0, 3'd2, B_INCR, 4'h1);
        setAr(32'h10, 8'd0, 3'd2, B_INCR, 4'h2);
        axiBus.axi_awvalid = 1'b1;
        axiBus.axi_arvalid = 1'b1;
        #1;
        checkOutput("arb2_arready", axiBus.axi_arready, 1);
        checkOutput("arb2_awready", axiBus.axi_awready, 0);
        @(posedge clk); #1;
        axiBus.axi_arvalid = 1'b0;
        readBeats(1);
        checkOutput("arb2_rdata", rdData[0], 32'd1);
        awHandshake();
        writeData(1, 0, 4'hF, 32'hAA);
        getB();
        checkOutput("arb2_bresp", bRespSeen, OKAY);
        applyRead(32'h40, 8'd0, 3'd2, B_INCR);
        checkOutput("arb2_readback", rdData[0], 32'hAA);

        // WRAP write at 0x18 hits 0x18, 0x1C, 0x10, 0x14.
        applyWrite(32'h18, 8'd3, 3'd2, B_WRAP, 4'hF, 32'h100);
        checkOutput("wrap_bresp", bRespSeen, OKAY);
        applyRead(32'h10, 8'd3, 3'd2, B_INCR);
        checkOutput("wrap_w0x10", rdData[0], 32'h102);
        checkOutput("wrap_w0x14", rdData[1], 32'h103);
        checkOutput("wrap_w0x18", rdData[2], 32'h100);
        checkOutput("wrap_w0x1C", rdData[3], 32'h101);
        applyRead(32'h18, 8'd3, 3'd2, B_WRAP);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("wrap_rd%0d", i), rdData[i], 32'h100 + 32'(i));
        end

        // FIXED burst keeps rewriting the same word.
        applyWrite(32'h30, 8'd1, 3'd2, B_FIXED, 4'hF, 32'd7);
        applyRead(32'h30, 8'd1, 3'd2, B_FIXED);
        checkOutput("fixed_rd0", rdData[0], 32'd8);
        checkOutput("fixed_rd1", rdData[1], 32'd8);

        // Out-of-range accesses: DECERR, zero data, memory untouched.
        applyWrite(32'h0, 8'd0, 3'd2, B_INCR, 4'hF, 32'hCAFE0000);
        applyRead(32'h1000, 8'd1, 3'd2, B_INCR);
        checkOutput("dec_rresp0", rdResp[0], DECERR);
        checkOutput("dec_rresp1", rdResp[1], DECERR);
        checkOutput("dec_rdata0", rdData[0], 0);
        checkOutput("dec_rdata1", rdData[1], 0);
        checkOutput("dec_rlast0", rdLast[0], 0);
        checkOutput("dec_rlast1", rdLast[1], 1);
        applyWrite(32'h1000, 8'd0, 3'd2, B_INCR, 4'hF, 32'h55);
        checkOutput("dec_bresp", bRespSeen, DECERR);
        applyRead(32'h0, 8'd0, 3'd2, B_INCR);
        checkOutput("dec_no_alias", rdData[0], 32'hCAFE0000);
        applyWrite(32'hFFC, 8'd1, 3'd2, B_INCR, 4'hF, 32'h77);
        checkOutput("edge_bresp", bRespSeen, DECERR);
        applyRead(32'hFFC, 8'd1, 3'd2, B_INCR);
        checkOutput("edge_rdata0", rdData[0], 32'h77);
        checkOutput("edge_rresp0", rdResp[0], OKAY);
        checkOutput("edge_rresp1", rdResp[1], DECERR);

        // Byte strobes and illegal burst descriptors.
        applyWrite(32'h20, 8'd0, 3'd2, B_INCR, 4'hF, 32'hFFFFFFFF);
        applyWrite(32'h20, 8'd0, 3'd2, B_INCR, 4'h5, 32'h11223344);
        applyRead(32'h20, 8'd0, 3'd2, B_INCR);
        checkOutput("strb_readback", rdData[0], 32'hFF22FF44);
        applyWrite(32'h20, 8'd0, 3'd2, B_RSVD, 4'hF, 32'h0);
        checkOutput("rsvd_bresp", bRespSeen, SLVERR);
        applyWrite(32'h20, 8'd2, 3'd2, B_WRAP, 4'hF, 32'h0);
        checkOutput("wraplen_bresp", bRespSeen, SLVERR);
        applyRead(32'h20, 8'd0, 3'd2, B_INCR);
        checkOutput("slverr_no_write", rdData[0], 32'hFF22FF44);
        applyRead(32'h20, 8'd0, 3'd2, B_RSVD);
        checkOutput("rsvd_rresp", rdResp[0], SLVERR);
        checkOutput("rsvd_rdata", rdData[0], 0);
        applyRead(32'h20, 8'd0, 3'd3, B_INCR);
        checkOutput("size_rresp", rdResp[0], SLVERR);
        applyRead(32'h22, 8'd1, 3'd2, B_WRAP);
        checkOutput("unaligned_rresp0", rdResp[0], SLVERR);
        checkOutput("unaligned_rresp1", rdResp[1], SLVERR);

        // wlast disagreeing with len, early and missing.
        setAw(32'h50, 8'd1, 3'd2, B_INCR, 4'h7);
        awHandshake();
        writeData(1, 0, 4'hF, 32'd9);
        getB();
        checkOutput("early_wlast_bresp", bRespSeen, SLVERR);
        checkOutput("early_wlast_bid", bIdSeen, 4'h7);
        setAw(32'h50, 8'd1, 3'd2, B_INCR, 4'h7);
        awHandshake();
        writeData(2, 99, 4'hF, 32'd9);
        getB();
        checkOutput("missing_wlast_bresp", bRespSeen, SLVERR);

        // Reset in the middle of a len=7 read, during its third beat.
        setAr(32'h10, 8'd7, 3'd2, B_INCR, 4'h6);
        arHandshake();
        readBeats(2);
        begin
            int t;
            t = 0;
            while (axiBus.axi_rvalid !== 1'b1 && t < LIMIT) begin
                @(posedge clk); #1; t++;
            end
            checkOutput("midrst_beat2_valid", axiBus.axi_rvalid, 1);
            checkOutput("midrst_beat2_data", axiBus.axi_rdata, 32'h100);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_rvalid", axiBus.axi_rvalid, 0);
        checkOutput("midrst_rdata", axiBus.axi_rdata, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        applyRead(32'h20, 8'd0, 3'd2, B_INCR);
        checkOutput("post_rst_rdata", rdData[0], 32'hFF22FF44);
        checkOutput("post_rst_rresp", rdResp[0], OKAY);
        applyRead(32'h10, 8'd1, 3'd2, B_INCR);
        checkOutput("post_rst_keep0", rdData[0], 32'h102);
        checkOutput("post_rst_keep1", rdData[1], 32'h103);
        checkOutput("post_rst_rlast", rdLast[1], 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
